fmap_replay_reader: RTL



---
 rtl/bnn_fmap_pkg.sv | 17 +
 rtl/fmap_skid_buf.sv | 47 ++++
 rtl/fmap_replay_reader.sv | 134 +++++++++++++
 3 files changed

// File: rtl/bnn_fmap_pkg.sv
// Shared constants and FSM encoding for the feature-map FIFO, the replay
// reader and the conv/popcount engine.
package bnn_fmap_pkg;

    localparam int DATA_W     = 32;   // FIFO word width (signed data)
    localparam int CNT_W      = 8;    // length / pass counter width
    localparam int FMAP_DEPTH = 150;  // largest legal words-per-pass

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REWIND,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } fmap_state_t;

endpackage

// File: rtl/fmap_skid_buf.sv
// Two-entry FIFO-ordered skid buffer. It has no ready output: the producer
// meters its pushes against occ, so a push never arrives when both slots are
// committed. The head entry is held until it is accepted downstream.
module fmap_skid_buf #(
    parameter int W = 34
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   occ
);

    logic [W-1:0] ent0, ent1;
    logic         pop;
    logic         fill_head;

    assign out_valid = (occ != 2'd0);
    assign out_data  = ent0;
    assign pop       = out_valid & out_ready;
    // A push lands in the head slot when the buffer is empty, or will be
    // empty after this cycle's pop.
    assign fill_head = (occ == 2'd0) | ((occ == 2'd1) & pop);

    // Entry shift on pop, write on push, occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent0 <= '0;
            ent1 <= '0;
            occ  <= 2'd0;
        end else begin
            if (pop)
                ent0 <= ent1;
            if (in_valid) begin
                if (fill_head)
                    ent0 <= in_data;
                else
                    ent1 <= in_data;
            end
            occ <= occ + {1'b0, in_valid} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/fmap_replay_reader.sv
// Feature-map replay reader: rewinds the FIFO read pointer once per pass and
// streams cfg_len words cfg_passes times. The FIFO's registered read data is
// absorbed by a 2-entry skid buffer; reads are issued only when the word in
// flight plus the buffered words are guaranteed to fit.
module fmap_replay_reader #(
    parameter int DATA_W     = bnn_fmap_pkg::DATA_W,
    parameter int CNT_W      = bnn_fmap_pkg::CNT_W,
    parameter int FMAP_DEPTH = bnn_fmap_pkg::FMAP_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [CNT_W-1:0]         cfg_len,
    input  logic [CNT_W-1:0]         cfg_passes,
    output logic                     fifo_rd_en,
    output logic                     fifo_rd_rst,
    input  logic                     fifo_empty,
    input  logic signed [DATA_W-1:0] fifo_dout,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [DATA_W-1:0] m_data,
    output logic                     m_last,
    output logic                     m_final,
    output logic                     busy,
    output logic                     done
);
    import bnn_fmap_pkg::*;

    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(FMAP_DEPTH);

    fmap_state_t       state, state_n;
    logic [CNT_W-1:0]  len_q, passes_q;
    logic [CNT_W-1:0]  word_cnt, pass_cnt;
    logic              inflight;
    logic              tag_last, tag_fin;
    logic [1:0]        occ;
    logic              pop, credit_ok, issue;
    logic              is_last, is_fin, cfg_zero;
    logic [DATA_W+1:0] skid_out;

    assign pop       = m_valid & m_ready;
    // Room check: what is buffered plus what is returning, minus what leaves
    // this cycle, must leave a free slot for the word issued now.
    assign credit_ok = ({1'b0, occ} + {2'b00, inflight}) <= (3'd1 + {2'b00, pop});
    assign issue     = (state == ST_RUN) & ~fifo_empty & credit_ok;
    assign is_last   = (word_cnt == len_q - 1'b1);
    assign is_fin    = is_last & (pass_cnt == passes_q - 1'b1);
    assign cfg_zero  = (cfg_len == '0) | (cfg_passes == '0);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    // Next-state logic. An empty job passes through DRAIN, which exits on the
    // next cycle because nothing is buffered.
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:   if (start) state_n = cfg_zero ? ST_DRAIN : ST_REWIND;
            ST_REWIND: state_n = ST_RUN;
            ST_RUN:    if (issue && is_last) state_n = is_fin ? ST_DRAIN : ST_REWIND;
            ST_DRAIN:  if (!inflight && occ == 2'd0) state_n = ST_DONE;
            ST_DONE:   state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        fifo_rd_en  = 1'b0;
        fifo_rd_rst = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            ST_REWIND: begin fifo_rd_rst = 1'b1; busy = 1'b1; end
            ST_RUN:    begin fifo_rd_en = issue; busy = 1'b1; end
            ST_DRAIN:  busy = 1'b1;
            ST_DONE:   done = 1'b1;
            default:   ;
        endcase
    end

    // Config latch, word/pass counters and the tags of the word in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q    <= '0;
            passes_q <= '0;
            word_cnt <= '0;
            pass_cnt <= '0;
            inflight <= 1'b0;
            tag_last <= 1'b0;
            tag_fin  <= 1'b0;
        end else begin
            inflight <= issue;
            if (state == ST_IDLE && start) begin
                len_q    <= (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
                passes_q <= cfg_passes;
                word_cnt <= '0;
                pass_cnt <= '0;
            end
            if (state == ST_REWIND)
                word_cnt <= '0;
            if (issue) begin
                tag_last <= is_last;
                tag_fin  <= is_fin;
                // Counters hold at their end values rather than wrapping.
                if (!is_last)
                    word_cnt <= word_cnt + 1'b1;
                else if (!is_fin)
                    pass_cnt <= pass_cnt + 1'b1;
            end
        end
    end

    fmap_skid_buf #(.W(DATA_W + 2)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_valid (inflight),
        .in_data  ({fifo_dout, tag_last, tag_fin}),
        .out_valid(m_valid),
        .out_ready(m_ready),
        .out_data (skid_out),
        .occ      (occ)
    );

    assign m_data  = skid_out[DATA_W+1:2];
    assign m_last  = skid_out[1];
    assign m_final = skid_out[0];

endmodule
